// File: rtl/prog_rom_pkg.sv
// Shared constants and FSM state type for the SPI-loadable program store.
package prog_rom_pkg;

  localparam int unsigned ADDR_W = 12;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrH,
    StAddrL,
    StWdata,
    StRdata,
    StIgnore
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with registered one-cycle
// rise and fall pulses taken from the synchronised level.
module sync_edge #(
  parameter bit ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/prog_rom_loader.sv
// 4 KiB CPU instruction store with an SPI-slave load/readback port; the CPU is
// held in reset during every SPI transaction and for RST_HOLD clk afterwards.
module prog_rom_loader
  import prog_rom_pkg::*;
#(
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_bus,
  output logic [7:0]        data_bus,
  output logic              cpu_rst,
  output logic              loading,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso
);

  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  logic [7:0] mem [MEM_DEPTH];

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_q;

  state_e            state_q, state_d;
  logic [2:0]        bit_q, bit_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        rx_byte;
  logic [7:0]        cmd_q, cmd_d;
  logic [3:0]        addr_h_q, addr_h_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic [7:0]        tx_q, tx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              loading_q, loading_d;
  logic              mem_we;

  sync_edge #(.ResetVal(1'b0)) u_sclk_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.ResetVal(1'b1)) u_cs_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (spi_cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign rx_byte = {rx_q, mosi_q};
  assign rd_addr = {addr_h_q, rx_byte};

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    rx_d      = rx_q;
    cmd_d     = cmd_q;
    addr_h_d  = addr_h_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    loading_d = loading_q;
    hold_d    = (hold_q != '0) ? hold_q - HoldW'(1) : hold_q;
    mem_we    = 1'b0;

    // cs_n edges win over any sclk edge detected in the same clk
    if (cs_fall) begin
      state_d   = StCmd;
      bit_d     = '0;
      tx_d      = '0;
      loading_d = 1'b1;
    end else if (cs_rise) begin
      state_d   = StIdle;
      bit_d     = '0;
      tx_d      = '0;
      loading_d = 1'b0;
      hold_d    = HoldW'(RST_HOLD);
    end else if (sclk_rise && state_q != StIdle) begin
      bit_d = bit_q + 3'd1;
      rx_d  = rx_byte[6:0];
      if (bit_q == 3'd7) begin
        case (state_q)
          StCmd: begin
            cmd_d   = rx_byte;
            state_d = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? StAddrH : StIgnore;
          end
          StAddrH: begin
            addr_h_d = rx_byte[3:0];
            state_d  = StAddrL;
          end
          StAddrL: begin
            if (cmd_q == CMD_WRITE) begin
              addr_d  = rd_addr;
              state_d = StWdata;
            end else begin
              tx_d    = mem[rd_addr];
              addr_d  = rd_addr + 12'd1;
              state_d = StRdata;
            end
          end
          StWdata: begin
            mem_we = 1'b1;
            addr_d = addr_q + 12'd1;
          end
          StRdata: begin
            tx_d   = mem[addr_q];
            addr_d = addr_q + 12'd1;
          end
          default: ;
        endcase
      end
    end else if (sclk_fall && bit_q != 3'd0) begin
      // The fall right after a byte boundary must not shift: the freshly loaded
      // MSB has to be on miso for the next rising edge.
      tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      state_q     <= StIdle;
      bit_q       <= '0;
      rx_q        <= '0;
      cmd_q       <= '0;
      addr_h_q    <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      hold_q      <= HoldW'(RST_HOLD);
      loading_q   <= 1'b0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_q      <= mosi_meta_q;
      state_q     <= state_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      cmd_q       <= cmd_d;
      addr_h_q    <= addr_h_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      hold_q      <= hold_d;
      loading_q   <= loading_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[addr_q] <= rx_byte;
    end
  end

  assign data_bus = mem[addr_bus];
  assign loading  = loading_q;
  assign cpu_rst  = rst | loading_q | (hold_q != '0);
  assign spi_miso = loading_q & tx_q[7];

endmodule
